alu_branch_resolver: RTL and testbench

- Consumer-side end of the ALU_16 flag interface.
- Latches the z/v/n flags produced by ALU_16 into a condition-code register.
- Resolves conditional branch requests against those flags over a valid/ready handshake, stalling while an in-flight ALU op still owes a flag update.
- Returns taken/not-taken and the next 16-bit PC to the fetch stage.

---
 rtl/alu_branch_resolver_if.sv | 41 ++++
 rtl/alu_branch_resolver.sv | 164 ++++++++++++++++
 tb/tb_alu_branch_resolver.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_branch_resolver_if.sv
// Signal bundle between the ALU_16 flag producer, the branch requester and the
// fetch stage on one side, and alu_branch_resolver on the other.
interface alu_branch_resolver_if #(
    parameter int DATA_W   = 16,
    parameter int OFFSET_W = 8,
    parameter int CNT_W    = 16
);
    logic                flag_we;
    logic                alu_z;
    logic                alu_v;
    logic                alu_n;
    logic                flag_busy;
    logic                br_valid;
    logic                br_ready;
    logic [3:0]          br_cond;
    logic [DATA_W-1:0]   br_pc;
    logic [OFFSET_W-1:0] br_offset;
    logic                res_valid;
    logic                res_ready;
    logic                res_taken;
    logic [DATA_W-1:0]   res_pc;
    logic                res_illegal;
    logic                cc_z;
    logic                cc_v;
    logic                cc_n;
    logic [CNT_W-1:0]    taken_cnt;

    modport master (
        output flag_we, alu_z, alu_v, alu_n, flag_busy,
        output br_valid, br_cond, br_pc, br_offset, res_ready,
        input  br_ready, res_valid, res_taken, res_pc, res_illegal,
        input  cc_z, cc_v, cc_n, taken_cnt
    );

    modport slave (
        input  flag_we, alu_z, alu_v, alu_n, flag_busy,
        input  br_valid, br_cond, br_pc, br_offset, res_ready,
        output br_ready, res_valid, res_taken, res_pc, res_illegal,
        output cc_z, cc_v, cc_n, taken_cnt
    );
endinterface

// File: rtl/alu_branch_resolver.sv
// Latches ALU_16 z/v/n flags and resolves conditional branches against them,
// returning taken/not-taken and the next PC over a valid/ready handshake.
module alu_branch_resolver #(
    parameter int DATA_W   = 16,
    parameter int OFFSET_W = 8,
    parameter int CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_branch_resolver_if.slave bus
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

    typedef enum logic [3:0] {
        CC_AL = 4'd0, CC_EQ = 4'd1, CC_NE = 4'd2, CC_LT = 4'd3,
        CC_GE = 4'd4, CC_GT = 4'd5, CC_LE = 4'd6, CC_VS = 4'd7,
        CC_VC = 4'd8, CC_MI = 4'd9, CC_PL = 4'd10
    } cond_e;

    state_e              state_q, state_d;
    logic                cc_z_q, cc_v_q, cc_n_q;
    logic                res_taken_q, res_taken_d;
    logic                res_illegal_q, res_illegal_d;
    logic [DATA_W-1:0]   res_pc_q, res_pc_d;
    logic [CNT_W-1:0]    taken_cnt_q, taken_cnt_d;
    logic [3:0]          cond_q;
    logic [DATA_W-1:0]   pc_q;
    logic [OFFSET_W-1:0] offset_q;

    logic                eval_en;
    logic [3:0]          sel_cond;
    logic [DATA_W-1:0]   sel_pc;
    logic [OFFSET_W-1:0] sel_offset;
    logic                eff_z, eff_v, eff_n, eff_lt;
    logic                eval_taken, eval_illegal;
    logic [DATA_W-1:0]   offset_ext;
    logic [DATA_W-1:0]   eval_pc;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        eval_en = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.br_valid) begin
                    if (bus.flag_busy && !bus.flag_we) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_RESP;
                        eval_en = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (bus.flag_we) begin
                    state_d = S_RESP;
                    eval_en = 1'b1;
                end
            end
            S_RESP: begin
                if (bus.res_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // IDLE evaluates the request on the bus; WAIT evaluates the captured copy.
    always_comb begin
        sel_cond   = (state_q == S_IDLE) ? bus.br_cond   : cond_q;
        sel_pc     = (state_q == S_IDLE) ? bus.br_pc     : pc_q;
        sel_offset = (state_q == S_IDLE) ? bus.br_offset : offset_q;
        eff_z      = bus.flag_we ? bus.alu_z : cc_z_q;
        eff_v      = bus.flag_we ? bus.alu_v : cc_v_q;
        eff_n      = bus.flag_we ? bus.alu_n : cc_n_q;
        eff_lt     = eff_n ^ eff_v;
    end

    always_comb begin
        eval_taken   = 1'b0;
        eval_illegal = 1'b0;
        case (sel_cond)
            CC_AL:   eval_taken = 1'b1;
            CC_EQ:   eval_taken = eff_z;
            CC_NE:   eval_taken = !eff_z;
            CC_LT:   eval_taken = eff_lt;
            CC_GE:   eval_taken = !eff_lt;
            CC_GT:   eval_taken = !eff_z && !eff_lt;
            CC_LE:   eval_taken = eff_z || eff_lt;
            CC_VS:   eval_taken = eff_v;
            CC_VC:   eval_taken = !eff_v;
            CC_MI:   eval_taken = eff_n;
            CC_PL:   eval_taken = !eff_n;
            default: eval_illegal = 1'b1;
        endcase
    end

    always_comb begin
        offset_ext = {{(DATA_W-OFFSET_W){sel_offset[OFFSET_W-1]}}, sel_offset};
        eval_pc    = eval_taken ? (sel_pc + DATA_W'(1) + offset_ext)
                                : (sel_pc + DATA_W'(1));
    end

    // The resolution is frozen once in RESP; later flag writes only touch cc_*.
    always_comb begin
        res_taken_d   = res_taken_q;
        res_illegal_d = res_illegal_q;
        res_pc_d      = res_pc_q;
        taken_cnt_d   = taken_cnt_q;
        if (eval_en) begin
            res_taken_d   = eval_taken;
            res_illegal_d = eval_illegal;
            res_pc_d      = eval_pc;
            if (eval_taken && (taken_cnt_q != {CNT_W{1'b1}})) begin
                taken_cnt_d = taken_cnt_q + CNT_W'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cc_z_q        <= 1'b1;
            cc_v_q        <= 1'b0;
            cc_n_q        <= 1'b0;
            res_taken_q   <= 1'b0;
            res_illegal_q <= 1'b0;
            res_pc_q      <= '0;
            taken_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            res_taken_q   <= res_taken_d;
            res_illegal_q <= res_illegal_d;
            res_pc_q      <= res_pc_d;
            taken_cnt_q   <= taken_cnt_d;
            if (bus.flag_we) begin
                cc_z_q <= bus.alu_z;
                cc_v_q <= bus.alu_v;
                cc_n_q <= bus.alu_n;
            end
        end
    end

    // NOTE: request capture registers are left unreset; WAIT only reads them after IDLE wrote them.
    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && bus.br_valid) begin
            cond_q   <= bus.br_cond;
            pc_q     <= bus.br_pc;
            offset_q <= bus.br_offset;
        end
    end

    assign bus.br_ready    = (state_q == S_IDLE);
    assign bus.res_valid   = (state_q == S_RESP);
    assign bus.res_taken   = res_taken_q;
    assign bus.res_pc      = res_pc_q;
    assign bus.res_illegal = res_illegal_q;
    assign bus.cc_z        = cc_z_q;
    assign bus.cc_v        = cc_v_q;
    assign bus.cc_n        = cc_n_q;
    assign bus.taken_cnt   = taken_cnt_q;

endmodule

// File: tb/tb_alu_branch_resolver.sv
// Directed bench for alu_branch_resolver: stimulus pushes hand-computed results
// into a scoreboard queue that a monitor pops on every resolution handshake.
module tb_alu_branch_resolver;

    localparam int DATA_W   = 16;
    localparam int OFFSET_W = 8;
    localparam int CNT_W    = 2;

    logic clk;
    logic rst_n;

    alu_branch_resolver_if #(.DATA_W(DATA_W), .OFFSET_W(OFFSET_W), .CNT_W(CNT_W)) bus ();

    alu_branch_resolver #(.DATA_W(DATA_W), .OFFSET_W(OFFSET_W), .CNT_W(CNT_W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        taken;
        logic        illegal;
        logic [15:0] pc;
    } exp_t;

    typedef struct {
        logic [3:0] cond;
        logic       z, v, n;
        logic       taken;
        logic       illegal;
    } vec_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Scoreboard monitor: one pop per accepted resolution.
    always @(negedge clk) begin
        if (rst_n && bus.res_valid && bus.res_ready) begin
            check("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("res_taken", 32'(bus.res_taken), 32'(e.taken));
                check("res_illegal", 32'(bus.res_illegal), 32'(e.illegal));
                check("res_pc", 32'(bus.res_pc), 32'(e.pc));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] cond, input logic [15:0] pc, input logic [7:0] off,
                         input logic exp_taken, input logic exp_illegal, input logic [15:0] exp_pc);
        exp_t e;
        e.taken   = exp_taken;
        e.illegal = exp_illegal;
        e.pc      = exp_pc;
        exp_q.push_back(e);
        bus.br_valid  = 1'b1;
        bus.br_cond   = cond;
        bus.br_pc     = pc;
        bus.br_offset = off;
        tick();
        bus.br_valid  = 1'b0;
    endtask

    task automatic set_flags(input logic we, input logic z, input logic v, input logic n);
        bus.flag_we = we;
        bus.alu_z   = z;
        bus.alu_v   = v;
        bus.alu_n   = n;
    endtask

    // LT request held in WAIT for three cycles, then released by a flag write.
    task automatic stall_case(input logic [15:0] pc, input logic n, input logic v,
                              input logic exp_taken, input logic [15:0] exp_pc, input int exp_cnt);
        bus.flag_busy = 1'b1;
        issue(4'd3, pc, 8'h10, exp_taken, 1'b0, exp_pc);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_br_ready", 32'(bus.br_ready), 32'd0);
            check("stall_res_valid", 32'(bus.res_valid), 32'd0);
            tick();
        end
        set_flags(1'b1, 1'b0, v, n);
        bus.flag_busy = 1'b0;
        tick();
        set_flags(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("stall_res_valid_after", 32'(bus.res_valid), 32'd1);
        check("stall_taken_cnt", 32'(bus.taken_cnt), 32'(exp_cnt));
        tick();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_cc_z"}, 32'(bus.cc_z), 32'd1);
        check({tag, "_cc_v"}, 32'(bus.cc_v), 32'd0);
        check({tag, "_cc_n"}, 32'(bus.cc_n), 32'd0);
        check({tag, "_res_valid"}, 32'(bus.res_valid), 32'd0);
        check({tag, "_res_taken"}, 32'(bus.res_taken), 32'd0);
        check({tag, "_res_pc"}, 32'(bus.res_pc), 32'd0);
        check({tag, "_res_illegal"}, 32'(bus.res_illegal), 32'd0);
        check({tag, "_taken_cnt"}, 32'(bus.taken_cnt), 32'd0);
        check({tag, "_br_ready"}, 32'(bus.br_ready), 32'd1);
    endtask

    vec_t vecs[13] = '{
        '{4'd2,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0},  // NE, z=1
        '{4'd5,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0},  // GT, all clear
        '{4'd5,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0},  // GT, negative
        '{4'd6,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0},  // LE, z=1
        '{4'd6,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0},  // LE, n^v=1
        '{4'd6,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0},  // LE, all clear
        '{4'd7,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0},  // VS
        '{4'd8,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0},  // VC with v=1
        '{4'd9,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0},  // MI
        '{4'd10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0},  // PL with n=1
        '{4'd4,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0},  // GE, n=v=1
        '{4'd1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0},  // EQ, z=0
        '{4'd15, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1}   // reserved
    };

    initial begin
        rst_n = 1'b0;
        set_flags(1'b0, 1'b0, 1'b0, 1'b0);
        bus.flag_busy = 1'b0;
        bus.br_valid  = 1'b0;
        bus.br_cond   = 4'd0;
        bus.br_pc     = '0;
        bus.br_offset = '0;
        bus.res_ready = 1'b1;
        tick();
        tick();
        @(negedge clk);
        check_reset_values("rst");
        tick();
        rst_n = 1'b1;
        tick();

        // AL with negative offset: 0x0100 + 1 - 16
        issue(4'd0, 16'h0100, 8'hF0, 1'b1, 1'b0, 16'h00F1);
        @(negedge clk);
        check("al_latency", 32'(bus.res_valid), 32'd1);
        check("al_taken_cnt", 32'(bus.taken_cnt), 32'd1);
        tick();

        // Bypass: stale cc_z=0, same-cycle flag write with z=1
        set_flags(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        set_flags(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("stale_cc_z", 32'(bus.cc_z), 32'd0);
        tick();
        set_flags(1'b1, 1'b1, 1'b0, 1'b0);
        issue(4'd1, 16'h0010, 8'h05, 1'b1, 1'b0, 16'h0016);
        set_flags(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("bypass_cc_z", 32'(bus.cc_z), 32'd1);
        check("bypass_taken_cnt", 32'(bus.taken_cnt), 32'd2);
        tick();

        // Stalled LT: n=1,v=0 taken; n=1,v=1 not taken
        stall_case(16'h0200, 1'b1, 1'b0, 1'b1, 16'h0211, 3);
        stall_case(16'h0300, 1'b1, 1'b1, 1'b0, 16'h0301, 3);

        // Backpressure with PC wrap: 0xFFFF + 1 + 0x7F = 0x007F
        set_flags(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        set_flags(1'b0, 1'b0, 1'b0, 1'b0);
        bus.res_ready = 1'b0;
        issue(4'd4, 16'hFFFF, 8'h7F, 1'b1, 1'b0, 16'h007F);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_res_valid", 32'(bus.res_valid), 32'd1);
            check("bp_res_pc", 32'(bus.res_pc), 32'h007F);
            check("bp_res_taken", 32'(bus.res_taken), 32'd1);
            check("bp_br_ready", 32'(bus.br_ready), 32'd0);
            tick();
            if (i == 1) set_flags(1'b1, 1'b1, 1'b0, 1'b1);
            if (i == 2) set_flags(1'b0, 1'b0, 1'b0, 1'b0);
        end
        check("resp_flag_write_cc_z", 32'(bus.cc_z), 32'd1);
        check("resp_flag_write_cc_n", 32'(bus.cc_n), 32'd1);
        bus.res_ready = 1'b1;
        tick();
        @(negedge clk);
        check("bp_done_br_ready", 32'(bus.br_ready), 32'd1);
        check("bp_done_res_valid", 32'(bus.res_valid), 32'd0);
        check("sat_taken_cnt", 32'(bus.taken_cnt), 32'd3);
        tick();

        // Reserved condition code 13
        issue(4'd13, 16'h0400, 8'h22, 1'b0, 1'b1, 16'h0401);
        @(negedge clk);
        check("reserved_illegal", 32'(bus.res_illegal), 32'd1);
        tick();

        // Reset while parked in WAIT: request must vanish
        bus.flag_busy = 1'b1;
        bus.br_valid  = 1'b1;
        bus.br_cond   = 4'd0;
        bus.br_pc     = 16'h0500;
        bus.br_offset = 8'h04;
        tick();
        bus.br_valid = 1'b0;
        @(negedge clk);
        check("wait_br_ready", 32'(bus.br_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("midrst");
        bus.flag_busy = 1'b0;
        set_flags(1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        set_flags(1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_no_res_valid", 32'(bus.res_valid), 32'd0);
            tick();
        end
        check("post_rst_cc_z", 32'(bus.cc_z), 32'd1);

        // Counter climbs 1,2,3 then holds at all-ones
        for (int k = 0; k < 4; k++) begin
            issue(4'd0, 16'h0FFF + 16'(k), 8'h01, 1'b1, 1'b0, 16'h1001 + 16'(k));
            @(negedge clk);
            check("cnt_saturate", 32'(bus.taken_cnt), (k < 3) ? 32'(k + 1) : 32'd3);
            tick();
        end

        // Remaining condition codes via bypass
        foreach (vecs[j]) begin
            set_flags(1'b1, vecs[j].z, vecs[j].v, vecs[j].n);
            issue(vecs[j].cond, 16'h1000, 8'h08, vecs[j].taken, vecs[j].illegal,
                  vecs[j].taken ? 16'h1009 : 16'h1001);
            set_flags(1'b0, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
            tick();
        end

        tick();
        tick();
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
